spi_target_regs: RTL and testbench
==================================

# spi_target_regs

SPI target (slave) endpoint exposing a small byte-wide register file to an SPI master over a 4-wire link. It decodes a command byte (read/write + address), then shifts data bytes in or out, with optional burst addressing. It is the responder counterpart of the team's SPI master and replaces the fixed-pattern slave models. It is the first slave that both stores master writes and returns stored data.

## Interface
Parameters:
- ADDR_W, 4: register address width, 1..7; register count = 2**ADDR_W.

Ports:
- sclk  input  1  serial clock from master; sole clock of the block
- rst  input  1  reset, synchronous, active-high
- ss_n  input  1  target select, active low
- mosi  input  1  master-out data, MSB first
- miso  output  1  target-out data, MSB first
- busy  output  1  frame in progress
- wr_stb  output  1  one-sclk pulse when a write byte commits
- wr_addr  output  ADDR_W  address of committed byte
- wr_data  output  8  committed byte
- reg_file  output  8*2**ADDR_W  all registers, register i at bits [8i+7:8i]

## Operation
- All inputs sampled, all state updated on rising sclk only. Master must supply at least one sclk rising edge with ss_n high between frames.
- ss_q: registered copy of ss_n. A frame starts on the edge where ss_n=0 and ss_q=1; that is edge 0.
- States: IDLE, CMD, WDATA, RDATA.
- IDLE -> CMD on frame start; edge 0 shifts in cmd bit 7.
- CMD: edges 0..7 shift mosi into cmd, MSB first. At edge 7: addr <= cmd[ADDR_W-1:0]; cmd[6:ADDR_W] ignored. If cmd[7]=1, go to RDATA and load tx_sh <= reg[addr]; otherwise go to WDATA.
- WDATA: 8 edges per byte. On the 8th edge, reg[addr] <= byte, wr_stb=1, wr_addr=addr, wr_data=byte, then advance addr.
- RDATA: miso = tx_sh[7], shifted left each edge. After 8 bits, tx_sh <= reg[next addr].
- Address advance (macro on): addr+1 mod 2**ADDR_W, so 2**ADDR_W-1 wraps to 0.
- ss_n sampled high in any non-IDLE state: -> IDLE. A partial byte is discarded, with no write and no wr_stb.
- miso is 0 whenever the state is not RDATA.
- busy = 1 in CMD, WDATA and RDATA.

## Timing
- Reset values: all registers 0x00, state IDLE, ss_q=0, miso=0, busy=0, wr_stb=0, wr_addr=0, wr_data=0, bit counter 0.
- Because ss_q resets to 0, a frame already in progress when reset releases is ignored until ss_n is sampled high.
- Edge k counts from frame start. Read: byte m bit (7-j) is driven on miso after edge 7+8m+j, stable until the next rising edge; the master samples it on edge 8+8m+j.
- Write byte m commits at edge 15+8m. wr_stb is high for exactly the sclk period after that edge. reg_file reflects the new value from the same edge.
- Rst high mid-frame: the reset values above apply at that edge and no write commits on that edge.
- A bit counter wraps 7->0 with no gap; back-to-back bytes need no idle edges.

## Configuration
- SPI_TGT_AUTOINC_EN defined: address advances after every data byte, with wrap-around (burst mode).
- Not defined: address is fixed for the whole frame. Burst writes overwrite the same register (wr_stb on each byte); burst reads repeat the same register.

## Structure
- Package spi_pkg holds:
  - state enum (IDLE, CMD, WDATA, RDATA)
  - CMD_RW_BIT = 7
  - BYTE_W = 8
- One sub-module, spi_shift8: 8-bit shift register with bit counter and byte-done flag. It is instantiated for rx and tx. The FSM and register file stay in the top.

## Test plan
- Write: reset, then frame with cmd 0x03 and data 0xA5 -> wr_stb at edge 15, wr_addr=3, wr_data=0xA5, reg_file[31:24]=0xA5, other registers 0.
- Read: after the write, frame with cmd 0x83 -> miso after edges 7..14 = 1,0,1,0,0,1,0,1 (0xA5); miso 0 during edges 0..6.
- Burst wrap (macro on, ADDR_W=4): cmd 0x0F, data 0x11,0x22,0x33 -> reg15=0x11, reg0=0x22, reg1=0x33; three wr_stb pulses at edges 15, 23, 31.
- Burst fixed (macro off): same stimulus -> reg15=0x33, reg0 and reg1 unchanged; three wr_stb pulses, all with wr_addr=15.
- Abort: cmd 0x05, 4 data bits, then ss_n high -> no wr_stb, reg5 unchanged, busy=0. The next frame starts cleanly from edge 0.
- Reset mid-frame: rst=1 at edge 10 of a write, with ss_n held low afterwards -> all registers 0, busy=0, no response until ss_n goes high then low.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state encoding and widths for the SPI target register block.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} spi_state_e;

  localparam int CMD_RW_BIT = 7;
  localparam int BYTE_W     = 8;

endpackage

// File: rtl/spi_shift8.sv
// Byte shifter with bit counter; done flags the edge that completes a byte.
// Parallel load wins over shift and restarts the count, so bytes run back to back.
module spi_shift8
  import spi_pkg::*;
(
  input  logic              sclk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_dat,
  input  logic              shift_en,
  input  logic              sin,
  output logic              msb,
  output logic [BYTE_W-1:0] byte_nxt,
  output logic              done
);

  logic [BYTE_W-1:0] sh;
  logic [2:0]        cnt;

  always_ff @(posedge sclk) begin
    if (rst || clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= load_dat;
      cnt <= '0;
    end else if (shift_en) begin
      sh  <= byte_nxt;
      cnt <= cnt + 3'd1;
    end
  end

  assign byte_nxt = {sh[BYTE_W-2:0], sin};
  assign msb      = sh[BYTE_W-1];
  assign done     = shift_en && (cnt == 3'd7);

endmodule

// File: rtl/spi_target_regs.sv
// SPI target with byte register file: command byte (rw + addr) then data bytes, no idle edges needed.
// Burst address increment with wrap when SPI_TGT_AUTOINC_EN is defined, otherwise fixed address per frame.
module spi_target_regs
  import spi_pkg::*;
#(
  parameter int ADDR_W = 4
)
(
  input  logic                           sclk,
  input  logic                           rst,
  input  logic                           ss_n,
  input  logic                           mosi,
  output logic                           miso,
  output logic                           busy,
  output logic                           wr_stb,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [BYTE_W-1:0]              wr_data,
  output logic [BYTE_W*(2**ADDR_W)-1:0]  reg_file
);

  localparam int NREG = 2**ADDR_W;

  spi_state_e        state;
  logic              ss_q;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] cmd_addr;
  logic [BYTE_W-1:0] regs [NREG];

  logic              frame_start;
  logic              rx_en, rx_done, rx_msb;
  logic [BYTE_W-1:0] rx_byte;
  logic              tx_en, tx_done, tx_load, tx_msb;
  logic [BYTE_W-1:0] tx_nxt, tx_load_dat;
  logic              unused_shift;

`ifdef SPI_TGT_AUTOINC_EN
  assign addr_nxt = addr + 1'b1;
`else
  assign addr_nxt = addr;
`endif

  // A frame only opens on a sampled high-to-low of ss_n, so a select held low through reset is ignored.
  assign frame_start = (state == IDLE) && !ss_n && ss_q;
  assign rx_en       = !ss_n && (frame_start || state == CMD || state == WDATA);
  assign tx_en       = !ss_n && (state == RDATA);
  assign cmd_addr    = rx_byte[ADDR_W-1:0];
  assign tx_load     = (state == CMD && rx_done && rx_byte[CMD_RW_BIT]) || tx_done;
  assign tx_load_dat = (state == CMD) ? regs[cmd_addr] : regs[addr_nxt];

  spi_shift8 u_rx (
    .sclk     (sclk),
    .rst      (rst),
    .clr      (ss_n),
    .load     (1'b0),
    .load_dat ('0),
    .shift_en (rx_en),
    .sin      (mosi),
    .msb      (rx_msb),
    .byte_nxt (rx_byte),
    .done     (rx_done)
  );

  spi_shift8 u_tx (
    .sclk     (sclk),
    .rst      (rst),
    .clr      (ss_n),
    .load     (tx_load),
    .load_dat (tx_load_dat),
    .shift_en (tx_en),
    .sin      (1'b0),
    .msb      (tx_msb),
    .byte_nxt (tx_nxt),
    .done     (tx_done)
  );

  assign unused_shift = ^{rx_msb, tx_nxt};

  always_ff @(posedge sclk) begin
    if (rst) begin
      state   <= IDLE;
      ss_q    <= 1'b0;
      addr    <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      ss_q   <= ss_n;
      wr_stb <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start) state <= CMD;
        end
        CMD: begin
          if (ss_n) begin
            state <= IDLE;
          end else if (rx_done) begin
            addr  <= cmd_addr;
            state <= rx_byte[CMD_RW_BIT] ? RDATA : WDATA;
          end
        end
        WDATA: begin
          if (ss_n) begin
            state <= IDLE;
          end else if (rx_done) begin
            regs[addr] <= rx_byte;
            wr_stb     <= 1'b1;
            wr_addr    <= addr;
            wr_data    <= rx_byte;
            addr       <= addr_nxt;
          end
        end
        RDATA: begin
          if (ss_n) begin
            state <= IDLE;
          end else if (tx_done) begin
            addr <= addr_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign miso = (state == RDATA) && tx_msb;
  assign busy = (state != IDLE);

  for (genvar g = 0; g < NREG; g++) begin : g_pack
    assign reg_file[g*BYTE_W +: BYTE_W] = regs[g];
  end

endmodule

// File: tb/tb_spi_target_regs.sv
// Random and directed SPI frames against a register-array model; a monitor checks every sclk edge.
module tb_spi_target_regs;

  localparam int AW   = 4;
  localparam int NREG = 1 << AW;

  logic              sclk = 1'b0;
  logic              rst;
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic              busy;
  logic              wr_stb;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        wr_data;
  logic [8*NREG-1:0] reg_file;

  typedef struct {
    bit busy;
    bit miso;
    bit stb;
    bit chk_rst;
  } exp_t;

  typedef struct {
    int         a;
    logic [7:0] d;
  } wr_t;

  exp_t       exp_q [$];
  wr_t        wr_q  [$];
  logic [7:0] model [NREG];
  int         n_cmp = 0;
  int         n_bad = 0;

  spi_target_regs #(.ADDR_W(AW)) dut (
    .sclk     (sclk),
    .rst      (rst),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .busy     (busy),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .reg_file (reg_file)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nxt(input int a);
`ifdef SPI_TGT_AUTOINC_EN
    return (a + 1) % NREG;
`else
    return a;
`endif
  endfunction

  function automatic exp_t quiet(input bit cr);
    exp_t e;
    e.busy = 1'b0; e.miso = 1'b0; e.stb = 1'b0; e.chk_rst = cr;
    return e;
  endfunction

  // One sclk edge: inputs change on the falling edge, expectation describes outputs after the next rising edge.
  task automatic step(input bit r, input bit s, input bit m, input exp_t e);
    @(negedge sclk);
    rst = r; ss_n = s; mosi = m;
    exp_q.push_back(e);
  endtask

  task automatic frame(input logic [7:0] cmd, input int nb, input logic [7:0] d [8],
                       input int extra, input int rst_edge);
    logic [7:0] rb [9];
    int   a, t, total;
    bit   rd, dead, bitv;
    exp_t e;
    wr_t  w;
    rd = cmd[7];
    a  = int'(cmd) % NREG;
    t  = a;
    for (int m = 0; m <= nb; m++) begin
      rb[m] = model[t];
      t = nxt(t);
    end
    total = 8 + 8*nb + extra;
    dead  = 1'b0;
    for (int k = 0; k < total; k++) begin
      bitv = (k < 8) ? cmd[7-k] : d[(k-8)/8][7-((k-8)%8)];
      e = quiet(1'b0);
      if (k == rst_edge) begin
        dead = 1'b1;
        e.chk_rst = 1'b1;
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;
      end else if (!dead) begin
        e.busy = 1'b1;
        if (rd && k >= 7) e.miso = rb[(k-7)/8][7-((k-7)%8)];
        if (!rd && k >= 15 && (k-15)%8 == 0) begin
          e.stb = 1'b1;
          w.a = a;
          w.d = d[(k-15)/8];
          model[a] = w.d;
          wr_q.push_back(w);
          a = nxt(a);
        end
      end
      step(k == rst_edge, 1'b0, bitv, e);
    end
    step(1'b0, 1'b1, 1'b0, quiet(1'b0));
  endtask

  initial begin : monitor
    exp_t e;
    wr_t  w;
    forever begin
      @(posedge sclk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("busy", 128'(busy), 128'(e.busy));
        check("miso", 128'(miso), 128'(e.miso));
        check("wr_stb", 128'(wr_stb), 128'(e.stb));
        if (wr_stb) begin
          check("wr_expected", 128'(wr_q.size() != 0), 128'(1));
          if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            check("wr_addr", 128'(wr_addr), 128'(w.a));
            check("wr_data", 128'(wr_data), 128'(w.d));
            check("reg_after_wr", 128'(reg_file[8*w.a +: 8]), 128'(w.d));
          end
        end
        if (e.chk_rst) begin
          check("rst_reg_file", 128'(reg_file), 128'(0));
          check("rst_wr_addr", 128'(wr_addr), 128'(0));
          check("rst_wr_data", 128'(wr_data), 128'(0));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] d [8];
    logic [7:0] cmd;
    int nb, extra, re;
    for (int i = 0; i < NREG; i++) model[i] = 8'h00;
    for (int i = 0; i < 8; i++) d[i] = 8'h00;
    rst = 1'b1; ss_n = 1'b0; mosi = 1'b0;

    // Select already low across reset release must not open a frame.
    step(1'b1, 1'b0, 1'b0, quiet(1'b1));
    step(1'b1, 1'b0, 1'b0, quiet(1'b1));
    repeat (3) step(1'b0, 1'b0, 1'b1, quiet(1'b0));
    step(1'b0, 1'b1, 1'b0, quiet(1'b0));

    d[0] = 8'hA5;
    frame(8'h03, 1, d, 0, -1);
    frame(8'h83, 1, d, 0, -1);
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    frame(8'h0F, 3, d, 0, -1);
    frame(8'h8F, 3, d, 0, -1);
    frame(8'h80, 2, d, 0, -1);
    d[0] = 8'h5A;
    frame(8'h05, 0, d, 4, -1);
    frame(8'h85, 1, d, 0, -1);
    d[0] = 8'hC3; d[1] = 8'h3C;
    frame(8'h0A, 2, d, 0, 10);
    frame(8'h8F, 1, d, 0, -1);

    for (int n = 0; n < 40; n++) begin
      cmd = 8'($urandom);
      nb  = $urandom_range(0, 3);
      for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      re    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8 + 8*nb - 1) : -1;
      frame(cmd, nb, d, extra, re);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), quiet(1'b0));
    end

    repeat (3) @(negedge sclk);
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    check("wr_q_drained", 128'(wr_q.size()), 128'(0));
    for (int i = 0; i < NREG; i++) check("final_reg", 128'(reg_file[8*i +: 8]), 128'(model[i]));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
